// File: rtl/data_memory_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// Each request waits LATENCY cycles, then its response is held until the initiator consumes it.
module data_memory_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q;
    logic [3:0]         cnt_q;
    logic               wr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic               err_q;
    logic               req_ready_q;
    logic               resp_valid_q;
    logic               resp_err_q;
    logic [31:0]        resp_rdata_q;

    // NOTE: the memory is zeroed by its declaration, never by rst, so contents survive a reset.
    logic [31:0]        mem_q [DEPTH] = '{default: 32'h0};

    logic               live_err_d;
    logic               acc_write_d;
    logic               acc_err_d;
    logic [IDX_W-1:0]   acc_idx_d;
    logic [31:0]        acc_wdata_d;
    logic               enter_resp_d;

    // The access happens on the edge entering RESP; with LATENCY=0 that is the accepting edge,
    // so the live request is used instead of the captured copy.
    // NOTE: always_comb assigns every output first, so no path can infer a latch.
    always_comb begin
        live_err_d  = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
        acc_write_d = wr_q;
        acc_err_d   = err_q;
        acc_idx_d   = idx_q;
        acc_wdata_d = wdata_q;
        if (state_q == IDLE) begin
            acc_write_d = req_write;
            acc_err_d   = live_err_d;
            acc_idx_d   = req_addr[IDX_W+1:2];
            acc_wdata_d = req_wdata;
        end
        enter_resp_d = !rst && (((state_q == IDLE) && req_valid && (LATENCY == 0)) ||
                                ((state_q == WAIT) && (cnt_q == 4'd0)));
    end

    always_ff @(posedge clk) begin
        if (enter_resp_d && acc_write_d && !acc_err_d) begin
            mem_q[acc_idx_d] <= acc_wdata_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wr_q        <= req_write;
                        idx_q       <= req_addr[IDX_W+1:2];
                        wdata_q     <= req_wdata;
                        err_q       <= live_err_d;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (enter_resp_d) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= acc_err_d;
                resp_rdata_q <= (acc_write_d || acc_err_d) ? 32'h0 : mem_q[acc_idx_d];
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: a LATENCY=2 instance for most scenarios
// and a LATENCY=0 instance for the zero-wait case.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        req_valid0, req_write0, resp_ready0;
    logic [31:0] req_addr0, req_wdata0;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH(64), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_memory_responder #(.DEPTH(64), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
        .req_addr(req_addr0), .req_wdata(req_wdata0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    // Called at a negedge with the DUT idle; returns at the negedge where resp_valid
    // is first seen, with lat = cycles after the accepting edge (20 means timeout).
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, output int lat);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready); else passes++;
        checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); else passes++;
        checks++; if (resp_err !== 1'b0) $display("FAIL reset_resp_err: got %b expected 0", resp_err); else passes++;
        checks++; if (resp_rdata !== 32'h0) $display("FAIL reset_resp_rdata: got %h expected 00000000", resp_rdata); else passes++;
    endtask

    task automatic test_store_load();
        int lat;
        issue(1'b1, 32'h10, 32'hDEADBEEF, lat);
        checks++; if (lat != 3) $display("FAIL store_latency: got %0d expected 3", lat); else passes++;
        checks++; if (resp_err !== 1'b0) $display("FAIL store_err: got %b expected 0", resp_err); else passes++;
        checks++; if (resp_rdata !== 32'h0) $display("FAIL store_rdata: got %h expected 00000000", resp_rdata); else passes++;
        consume();
        issue(1'b0, 32'h10, 32'h0, lat);
        checks++; if (lat != 3) $display("FAIL load_latency: got %0d expected 3", lat); else passes++;
        checks++; if (resp_rdata !== 32'hDEADBEEF) $display("FAIL load_rdata: got %h expected deadbeef", resp_rdata); else passes++;
        checks++; if (resp_err !== 1'b0) $display("FAIL load_err: got %b expected 0", resp_err); else passes++;
        consume();
    endtask

    // Stalls the response for 5 cycles while a different request is offered, which must be ignored.
    task automatic test_backpressure();
        int lat;
        issue(1'b0, 32'h10, 32'h0, lat);
        checks++; if (lat != 3) $display("FAIL bp_latency: got %0d expected 3", lat); else passes++;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0BADF00D;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b expected 1", i, resp_valid); else passes++;
            checks++; if (resp_rdata !== 32'hDEADBEEF) $display("FAIL bp_rdata[%0d]: got %h expected deadbeef", i, resp_rdata); else passes++;
            checks++; if (req_ready !== 1'b0) $display("FAIL bp_req_ready[%0d]: got %b expected 0", i, req_ready); else passes++;
        end
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        consume();
        checks++; if (req_ready !== 1'b1) $display("FAIL bp_idle_ready: got %b expected 1", req_ready); else passes++;
        checks++; if (resp_valid !== 1'b0) $display("FAIL bp_idle_valid: got %b expected 0", resp_valid); else passes++;
        issue(1'b0, 32'h10, 32'h0, lat);
        checks++; if (resp_rdata !== 32'hDEADBEEF) $display("FAIL bp_ignored_store: got %h expected deadbeef", resp_rdata); else passes++;
        consume();
    endtask

    task automatic test_errors();
        int lat;
        issue(1'b0, 32'h12, 32'h0, lat);
        checks++; if (lat != 3) $display("FAIL misalign_latency: got %0d expected 3", lat); else passes++;
        checks++; if (resp_err !== 1'b1) $display("FAIL misalign_err: got %b expected 1", resp_err); else passes++;
        checks++; if (resp_rdata !== 32'h0) $display("FAIL misalign_rdata: got %h expected 00000000", resp_rdata); else passes++;
        consume();
        issue(1'b1, 32'h100, 32'h55, lat);
        checks++; if (resp_err !== 1'b1) $display("FAIL range_err: got %b expected 1", resp_err); else passes++;
        checks++; if (resp_rdata !== 32'h0) $display("FAIL range_rdata: got %h expected 00000000", resp_rdata); else passes++;
        consume();
        issue(1'b0, 32'h0, 32'h0, lat);
        checks++; if (resp_rdata !== 32'h0) $display("FAIL range_word0: got %h expected 00000000", resp_rdata); else passes++;
        checks++; if (resp_err !== 1'b0) $display("FAIL range_word0_err: got %b expected 0", resp_err); else passes++;
        consume();
    endtask

    task automatic test_latency0();
        int lat;
        req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 32'h0;
        @(negedge clk);
        req_valid0 = 1'b0;
        lat = 1;
        while (!resp_valid0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 1) $display("FAIL lat0_latency: got %0d expected 1", lat); else passes++;
        checks++; if (resp_rdata0 !== 32'h0) $display("FAIL lat0_rdata: got %h expected 00000000", resp_rdata0); else passes++;
        checks++; if (resp_err0 !== 1'b0) $display("FAIL lat0_err: got %b expected 0", resp_err0); else passes++;
        resp_ready0 = 1'b1;
        @(negedge clk);
        resp_ready0 = 1'b0;
        checks++; if (req_ready0 !== 1'b1) $display("FAIL lat0_idle: got %b expected 1", req_ready0); else passes++;
    endtask

    task automatic test_reset_mid_wait();
        int lat;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) $display("FAIL abort_req_ready: got %b expected 1", req_ready); else passes++;
        checks++; if (resp_valid !== 1'b0) $display("FAIL abort_resp_valid: got %b expected 0", resp_valid); else passes++;
        issue(1'b0, 32'h20, 32'h0, lat);
        checks++; if (resp_rdata !== 32'h0) $display("FAIL abort_load: got %h expected 00000000", resp_rdata); else passes++;
        consume();
        issue(1'b0, 32'h10, 32'h0, lat);
        checks++; if (resp_rdata !== 32'hDEADBEEF) $display("FAIL reset_keeps_mem: got %h expected deadbeef", resp_rdata); else passes++;
        consume();
    endtask

    // Acceptances are seen at negedges where req_valid and req_ready are both high.
    task automatic test_back_to_back();
        int n_acc = 0;
        int last = -1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; resp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                if (last >= 0) begin
                    checks++; if (i - last != 4) $display("FAIL b2b_spacing[%0d]: got %0d expected 4", i, i - last); else passes++;
                end
                last = i;
                n_acc++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0; req_addr = 32'h0;
        checks++; if (n_acc != 5) $display("FAIL b2b_count: got %0d expected 5", n_acc); else passes++;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1) $display("FAIL b2b_idle: got %b expected 1", req_ready); else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = 32'h0; req_wdata0 = 32'h0; resp_ready0 = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency0();
        test_store_load();
        test_backpressure();
        test_errors();
        test_reset_mid_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 2, SHALL set the number of wait cycles between request acceptance and response (legal range 0-15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 req_valid  input  1  SHALL indicate that the initiator presents a request.
REQ-006 req_ready  output  1  SHALL indicate that the block can accept a request this cycle.
REQ-007 req_write  input  1  SHALL select the request type: 1 = store, 0 = load.
REQ-008 req_addr  input  32  SHALL carry the byte address of the request.
REQ-009 req_wdata  input  32  SHALL carry the store data.
REQ-010 resp_valid  output  1  SHALL indicate that a response is presented.
REQ-011 resp_ready  input  1  SHALL indicate that the initiator accepts the response.
REQ-012 resp_rdata  output  32  SHALL carry the load data; 0 for stores and errored requests.
REQ-013 resp_err  output  1  SHALL flag a misaligned or out-of-range request.

Function
REQ-014 The FSM SHALL have three states, IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted on a rising edge where state=IDLE and req_valid=1; req_write, req_addr and req_wdata SHALL be captured on that edge.
REQ-016 On acceptance the FSM SHALL go to WAIT with counter=LATENCY-1, or directly to RESP when LATENCY=0.
REQ-017 In WAIT the counter SHALL decrement each cycle; on the edge where counter=0 the FSM SHALL go to RESP.
REQ-018 resp_valid SHALL first be high in cycle LATENCY+1 after the accepting edge.
REQ-019 The memory access SHALL be performed on the edge that enters RESP: a store writes the captured word, and a load registers the word into resp_rdata.
REQ-020 In RESP, resp_valid=1 SHALL hold with resp_rdata and resp_err stable until an edge with resp_ready=1; the FSM SHALL then go to IDLE.
REQ-021 A new request SHALL NOT be accepted on the same edge as a response is consumed; minimum request spacing SHALL be LATENCY+2 cycles.
REQ-022 The word index SHALL be req_addr[31:2]; the request is errored when req_addr[1:0]!=0 or the index is >= DEPTH.
REQ-023 An errored request SHALL follow the same timing, SHALL NOT modify memory, and SHALL return resp_err=1 and resp_rdata=0.
REQ-024 Input changes while the FSM is not in IDLE SHALL have no effect.
REQ-025 Memory SHALL initialise to all zeros at time 0.

Reset
REQ-026 When rst=1 on an edge, the FSM SHALL go to IDLE and the counter SHALL clear to 0.
REQ-027 Reset values: resp_valid=0, resp_err=0, resp_rdata=0, req_ready=1 in the first cycle after reset.
REQ-028 Memory contents SHALL NOT be altered by reset.
REQ-029 A reset mid-operation (WAIT or RESP) SHALL abort the transaction; a store aborted in WAIT SHALL NOT be written.
REQ-030 rst SHALL take priority over every other input on the same edge.

Verification
REQ-031 Store then load, LATENCY=2: store addr 0x10, data 0xDEADBEEF; then load addr 0x10 -> each response appears in cycle 3 after acceptance; the load returns resp_rdata=0xDEADBEEF, resp_err=0.
REQ-032 Backpressure: hold resp_ready=0 for 5 cycles during a load of addr 0x10 -> resp_valid and resp_rdata=0xDEADBEEF stay stable and req_ready=0 throughout; the FSM returns to IDLE one edge after resp_ready=1.
REQ-033 Errors: load addr 0x12 -> resp_err=1, rdata=0; store 0x55 to addr 0x100 (index 64 >= DEPTH) -> resp_err=1, and a later load of word 0 returns its unchanged value.
REQ-034 LATENCY=0 build: load addr 0x0 after reset -> resp_valid high in the first cycle after acceptance, rdata=0.
REQ-035 Reset mid-WAIT: accept a store of 0x1234 to addr 0x20, assert rst in the first WAIT cycle -> req_ready=1 and resp_valid=0 after reset; a later load of 0x20 returns 0.
REQ-036 Back-to-back traffic: hold req_valid=1 for 20 cycles with resp_ready=1 -> exactly one acceptance every LATENCY+2 cycles.
